// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI4-Lite bridge: FSM state encodings
// and AXI response codes.
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D_RD = 3'd1,
        D_WR = 3'd2,
        I_RD = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data SRAM ports onto one AXI4-Lite master, one
// transaction at a time with data first; stallreq_axi freezes the pipeline meanwhile.
import sram_axi_bridge_pkg::*;

module sram_axi_bridge #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_sram_en,
    input  logic [DATA_W/8-1:0] inst_sram_we,
    input  logic [ADDR_W-1:0]   inst_sram_addr,
    input  logic [DATA_W-1:0]   inst_sram_wdata,
    output logic [DATA_W-1:0]   inst_sram_rdata,

    input  logic                data_sram_en,
    input  logic [DATA_W/8-1:0] data_sram_we,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic [DATA_W-1:0]   data_sram_rdata,

    output logic                stallreq_axi,

    output logic [ADDR_W-1:0]   axi_araddr,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    input  logic [DATA_W-1:0]   axi_rdata,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rvalid,
    output logic                axi_rready,

    output logic [ADDR_W-1:0]   axi_awaddr,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [DATA_W-1:0]   axi_wdata,
    output logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    input  logic [1:0]          axi_bresp,
    input  logic                axi_bvalid,
    output logic                axi_bready
);

    state_t state, state_nxt;

    logic                pend_d, pend_i;
    logic [ADDR_W-1:0]   d_addr, i_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_we;
    logic                ar_done, aw_done, w_done;
    logic [DATA_W-1:0]   inst_rdata_q, data_rdata_q;
    logic [1:0]          dbg_rresp, dbg_bresp;

    logic any_en;
    logic r_hs, b_hs;

    assign any_en = inst_sram_en | data_sram_en;
    assign r_hs   = axi_rvalid & axi_rready;
    assign b_hs   = axi_bvalid & axi_bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        case (state)
            IDLE: begin
                if (data_sram_en && (|data_sram_we)) begin
                    state_nxt = D_WR;
                end else if (data_sram_en) begin
                    state_nxt = D_RD;
                end else if (inst_sram_en) begin
                    state_nxt = I_RD;
                end
            end
            D_RD: begin
                axi_arvalid = ~ar_done;
                axi_rready  = ar_done;
                if (axi_rvalid && ar_done) begin
                    state_nxt = pend_i ? I_RD : DONE;
                end
            end
            D_WR: begin
                axi_awvalid = ~aw_done;
                axi_wvalid  = ~w_done;
                axi_bready  = aw_done & w_done;
                if (axi_bvalid && aw_done && w_done) begin
                    state_nxt = pend_i ? I_RD : DONE;
                end
            end
            I_RD: begin
                axi_arvalid = ~ar_done;
                axi_rready  = ar_done;
                if (axi_rvalid && ar_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Pipeline advances this cycle; its enables still describe the served request.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_d       <= 1'b0;
            pend_i       <= 1'b0;
            d_addr       <= '0;
            i_addr       <= '0;
            d_wdata      <= '0;
            d_we         <= '0;
            ar_done      <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            dbg_rresp    <= RESP_OKAY;
            dbg_bresp    <= RESP_OKAY;
        end else begin
            if (state == IDLE && any_en) begin
                pend_d  <= data_sram_en;
                pend_i  <= inst_sram_en;
                d_addr  <= data_sram_addr;
                d_wdata <= data_sram_wdata;
                d_we    <= data_sram_we;
                i_addr  <= inst_sram_addr;
            end
            if (axi_arvalid && axi_arready) begin
                ar_done <= 1'b1;
            end
            if (r_hs) begin
                ar_done   <= 1'b0;
                dbg_rresp <= axi_rresp;
                if (state == I_RD) begin
                    inst_rdata_q <= axi_rdata;
                    pend_i       <= 1'b0;
                end else begin
                    data_rdata_q <= axi_rdata;
                    pend_d       <= 1'b0;
                end
            end
            if (axi_awvalid && axi_awready) begin
                aw_done <= 1'b1;
            end
            if (axi_wvalid && axi_wready) begin
                w_done <= 1'b1;
            end
            if (b_hs) begin
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                pend_d    <= 1'b0;
                dbg_bresp <= axi_bresp;
            end
        end
    end

    assign stallreq_axi = ((state == IDLE) & any_en) | ((state != IDLE) & (state != DONE));

    assign axi_araddr = (state == I_RD) ? i_addr : d_addr;
    assign axi_awaddr = d_addr;
    assign axi_wdata  = d_wdata;
    assign axi_wstrb  = d_we;

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed cycle-by-cycle bench for sram_axi_bridge; the slave side is driven by hand.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en, data_sram_en;
    logic [7:0]  inst_sram_we, data_sram_we;
    logic [63:0] inst_sram_addr, data_sram_addr, inst_sram_wdata, data_sram_wdata;
    logic [63:0] inst_sram_rdata, data_sram_rdata;
    logic        stallreq_axi;
    logic [63:0] axi_araddr, axi_awaddr, axi_wdata, axi_rdata;
    logic [7:0]  axi_wstrb;
    logic        axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready;
    logic        axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid;
    logic [1:0]  axi_rresp, axi_bresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .stallreq_axi(stallreq_axi),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs are driven and outputs sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        inst_sram_en = 0; data_sram_en = 0;
        inst_sram_we = 0; data_sram_we = 0;
        inst_sram_addr = 0; data_sram_addr = 0;
        inst_sram_wdata = 0; data_sram_wdata = 0;
        axi_arready = 0; axi_awready = 0; axi_wready = 0;
        axi_rvalid = 0; axi_bvalid = 0; axi_rdata = 0;
        axi_rresp = 0; axi_bresp = 0;
        step(); step();
        rst = 1'b0;
        settle();

        // reset state
        chk("rst_stall", stallreq_axi, 0);
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_wvalid", axi_wvalid, 0);
        chk("rst_rready", axi_rready, 0);
        chk("rst_bready", axi_bready, 0);
        chk("rst_inst_rdata", inst_sram_rdata, 0);
        chk("rst_data_rdata", data_sram_rdata, 0);

        // T1: instruction read, zero-wait slave
        step();
        inst_sram_en = 1; inst_sram_addr = 64'h8000_0000; axi_arready = 1;
        settle();
        chk("t1_c0_stall", stallreq_axi, 1);
        chk("t1_c0_arvalid", axi_arvalid, 0);
        step();
        inst_sram_en = 0; inst_sram_addr = 64'h0;
        settle();
        chk("t1_c1_arvalid", axi_arvalid, 1);
        chk("t1_c1_araddr", axi_araddr, 64'h8000_0000);
        chk("t1_c1_rready", axi_rready, 0);
        chk("t1_c1_stall", stallreq_axi, 1);
        step();
        axi_rvalid = 1; axi_rdata = 64'h0000_0013_0000_0093;
        settle();
        chk("t1_c2_arvalid", axi_arvalid, 0);
        chk("t1_c2_rready", axi_rready, 1);
        chk("t1_c2_stall", stallreq_axi, 1);
        step();
        axi_rvalid = 0; axi_rdata = 64'h0;
        settle();
        chk("t1_c3_stall", stallreq_axi, 0);
        chk("t1_c3_rready", axi_rready, 0);
        step();
        chk("t1_c4_inst_rdata", inst_sram_rdata, 64'h0000_0013_0000_0093);
        chk("t1_c4_stall", stallreq_axi, 0);
        step();
        chk("t1_c5_inst_rdata_hold", inst_sram_rdata, 64'h0000_0013_0000_0093);

        // T2: data write plus instruction fetch in the same cycle
        data_sram_en = 1; data_sram_we = 8'hFF; data_sram_addr = 64'h100;
        data_sram_wdata = 64'hDEAD_BEEF;
        inst_sram_en = 1; inst_sram_addr = 64'h8000_0004;
        axi_awready = 1; axi_wready = 1; axi_arready = 1;
        settle();
        chk("t2_c0_stall", stallreq_axi, 1);
        step();
        data_sram_en = 0; inst_sram_en = 0; data_sram_we = 0;
        data_sram_addr = 0; data_sram_wdata = 0; inst_sram_addr = 0;
        settle();
        chk("t2_c1_awvalid", axi_awvalid, 1);
        chk("t2_c1_wvalid", axi_wvalid, 1);
        chk("t2_c1_arvalid", axi_arvalid, 0);
        chk("t2_c1_awaddr", axi_awaddr, 64'h100);
        chk("t2_c1_wdata", axi_wdata, 64'hDEAD_BEEF);
        chk("t2_c1_wstrb", {56'h0, axi_wstrb}, 64'hFF);
        step();
        axi_bvalid = 1;
        settle();
        chk("t2_c2_awvalid", axi_awvalid, 0);
        chk("t2_c2_bready", axi_bready, 1);
        chk("t2_c2_arvalid", axi_arvalid, 0);
        chk("t2_c2_stall", stallreq_axi, 1);
        step();
        axi_bvalid = 0;
        settle();
        chk("t2_c3_arvalid", axi_arvalid, 1);
        chk("t2_c3_araddr", axi_araddr, 64'h8000_0004);
        chk("t2_c3_bready", axi_bready, 0);
        chk("t2_c3_stall", stallreq_axi, 1);
        step();
        axi_rvalid = 1; axi_rdata = 64'h1111_2222_3333_4444;
        settle();
        chk("t2_c4_rready", axi_rready, 1);
        chk("t2_c4_stall", stallreq_axi, 1);
        step();
        axi_rvalid = 0; axi_rdata = 0;
        settle();
        chk("t2_c5_stall", stallreq_axi, 0);
        chk("t2_c5_inst_rdata", inst_sram_rdata, 64'h1111_2222_3333_4444);
        chk("t2_c5_data_rdata_untouched", data_sram_rdata, 0);
        step();

        // T3: AWREADY delayed three cycles, WREADY immediate
        data_sram_en = 1; data_sram_we = 8'h0F; data_sram_addr = 64'h200;
        data_sram_wdata = 64'h1234;
        axi_awready = 0; axi_wready = 1;
        settle();
        step();
        data_sram_en = 0; data_sram_we = 0; data_sram_addr = 0; data_sram_wdata = 0;
        settle();
        chk("t3_c1_awvalid", axi_awvalid, 1);
        chk("t3_c1_wvalid", axi_wvalid, 1);
        chk("t3_c1_wstrb", {56'h0, axi_wstrb}, 64'h0F);
        for (int c = 2; c <= 3; c++) begin
            step();
            chk($sformatf("t3_c%0d_awvalid", c), axi_awvalid, 1);
            chk($sformatf("t3_c%0d_wvalid", c), axi_wvalid, 0);
            chk($sformatf("t3_c%0d_bready", c), axi_bready, 0);
        end
        step();
        axi_awready = 1;
        settle();
        chk("t3_c4_awvalid", axi_awvalid, 1);
        chk("t3_c4_awaddr", axi_awaddr, 64'h200);
        chk("t3_c4_bready", axi_bready, 0);
        step();
        axi_bvalid = 1;
        settle();
        chk("t3_c5_awvalid", axi_awvalid, 0);
        chk("t3_c5_bready", axi_bready, 1);
        step();
        axi_bvalid = 0;
        settle();
        chk("t3_c6_stall", stallreq_axi, 0);
        chk("t3_c6_data_rdata", data_sram_rdata, 0);
        step();

        // T4: data read, rvalid five cycles late
        data_sram_en = 1; data_sram_addr = 64'h300; axi_arready = 1;
        settle();
        step();
        data_sram_en = 0; data_sram_addr = 0;
        settle();
        chk("t4_c1_arvalid", axi_arvalid, 1);
        chk("t4_c1_araddr", axi_araddr, 64'h300);
        axi_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int c = 2; c <= 6; c++) begin
            step();
            chk($sformatf("t4_c%0d_stall", c), stallreq_axi, 1);
            chk($sformatf("t4_c%0d_data_rdata", c), data_sram_rdata, 0);
        end
        step();
        axi_rvalid = 1; axi_rdata = 64'hCAFE_F00D_0123_4567;
        settle();
        chk("t4_c7_rready", axi_rready, 1);
        step();
        axi_rdata = 64'hFFFF_0000_FFFF_0000;
        settle();
        chk("t4_c8_stall", stallreq_axi, 0);
        chk("t4_c8_rready", axi_rready, 0);
        chk("t4_c8_data_rdata", data_sram_rdata, 64'hCAFE_F00D_0123_4567);
        step();
        chk("t4_c9_data_rdata_once", data_sram_rdata, 64'hCAFE_F00D_0123_4567);
        axi_rvalid = 0; axi_rdata = 0;

        // T5: reset during the D_RD address wait
        data_sram_en = 1; data_sram_addr = 64'h400; axi_arready = 0;
        settle();
        step();
        data_sram_en = 0; data_sram_addr = 0;
        settle();
        chk("t5_c1_arvalid", axi_arvalid, 1);
        step();
        chk("t5_c2_arvalid_held", axi_arvalid, 1);
        chk("t5_c2_araddr_held", axi_araddr, 64'h400);
        rst = 1;
        step();
        rst = 0;
        settle();
        chk("t5_arvalid", axi_arvalid, 0);
        chk("t5_stall", stallreq_axi, 0);
        chk("t5_rready", axi_rready, 0);
        chk("t5_inst_rdata", inst_sram_rdata, 0);
        chk("t5_data_rdata", data_sram_rdata, 0);
        step();
        chk("t5_next_arvalid", axi_arvalid, 0);

        // T6: enables stay high through DONE
        inst_sram_en = 1; inst_sram_addr = 64'h8000_0010; axi_arready = 1;
        settle();
        step();
        settle();
        chk("t6_c1_araddr", axi_araddr, 64'h8000_0010);
        step();
        axi_rvalid = 1; axi_rdata = 64'hA5A5;
        settle();
        step();
        axi_rvalid = 0; axi_rdata = 0; inst_sram_addr = 64'h8000_0020;
        settle();
        chk("t6_done_arvalid", axi_arvalid, 0);
        chk("t6_done_stall", stallreq_axi, 0);
        chk("t6_done_inst_rdata", inst_sram_rdata, 64'hA5A5);
        step();
        chk("t6_idle_stall", stallreq_axi, 1);
        chk("t6_idle_arvalid", axi_arvalid, 0);
        step();
        chk("t6_new_arvalid", axi_arvalid, 1);
        chk("t6_new_araddr", axi_araddr, 64'h8000_0020);
        step();
        axi_rvalid = 1; axi_rdata = 64'h5A5A;
        settle();
        step();
        axi_rvalid = 0; axi_rdata = 0; inst_sram_en = 0;
        settle();
        chk("t6_new_inst_rdata", inst_sram_rdata, 64'h5A5A);
        step();
        chk("t6_final_stall", stallreq_axi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
